// File: rtl/nn_cfg_pkg.sv
// nn_cfg_pkg
// Shared definitions for the zyNet configuration sequencer: slave register
// offsets, the OKAY write-response code and the sequencer state encoding.
package nn_cfg_pkg;

   // zyNet slave register map (byte offsets)
   localparam logic [31:0] ADDR_WEIGHT = 32'd0;
   localparam logic [31:0] ADDR_BIAS   = 32'd4;
   localparam logic [31:0] ADDR_LAYER  = 32'd12;
   localparam logic [31:0] ADDR_NEURON = 32'd16;
   localparam logic [31:0] ADDR_SRST   = 32'd28;

   localparam logic [1:0]  BRESP_OKAY  = 2'b00;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_SRST     = 4'd1,
      ST_LAYER_W  = 4'd2,
      ST_NEURON_W = 4'd3,
      ST_FETCH_W  = 4'd4,
      ST_WEIGHT   = 4'd5,
      ST_LAYER_B  = 4'd6,
      ST_NEURON_B = 4'd7,
      ST_FETCH_B  = 4'd8,
      ST_BIAS     = 4'd9,
      ST_WAIT_B   = 4'd10,
      ST_FINISH   = 4'd11
   } state_t;

endpackage

// File: rtl/axil_single_write.sv
// axil_single_write
// Runs one AXI4-Lite write transaction per req pulse. Address and data are
// latched on req; awvalid/wvalid rise together and each falls on its own
// handshake. bready is held from issue until the B handshake, at which point
// ack pulses (combinationally) with resp_err flagging a non-OKAY response.
// Ports:
//   s_axi_aclk, s_axi_aresetn : clock, async active-low reset
//   req, addr, data           : start a write (only while no write is pending)
//   ack, resp_err             : B handshake seen / response was not OKAY
//   m_axi_*                   : AXI4-Lite write channels (AW, W, B)
module axil_single_write
   import nn_cfg_pkg::*;
(
   input  logic        s_axi_aclk,
   input  logic        s_axi_aresetn,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   output logic        ack,
   output logic        resp_err,
   output logic [31:0] m_axi_awaddr,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready
);

   logic [31:0] awaddr_r;
   logic [31:0] wdata_r;
   logic        awvalid_r;
   logic        wvalid_r;
   logic        bready_r;

   // Channel registers: launch on req, retire each channel on its handshake
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         awaddr_r  <= 32'd0;
         wdata_r   <= 32'd0;
         awvalid_r <= 1'b0;
         wvalid_r  <= 1'b0;
         bready_r  <= 1'b0;
      end else if (req) begin
         awaddr_r  <= addr;
         wdata_r   <= data;
         awvalid_r <= 1'b1;
         wvalid_r  <= 1'b1;
         bready_r  <= 1'b1;
      end else begin
         if (awvalid_r && m_axi_awready) begin
            awvalid_r <= 1'b0;
         end
         if (wvalid_r && m_axi_wready) begin
            wvalid_r <= 1'b0;
         end
         if (bready_r && m_axi_bvalid) begin
            bready_r <= 1'b0;
         end
      end
   end

   // Completion strobe and error flag for the sequencer
   always_comb begin
      ack      = 1'b0;
      resp_err = 1'b0;
      if (bready_r && m_axi_bvalid) begin
         ack      = 1'b1;
         resp_err = (m_axi_bresp != BRESP_OKAY);
      end else begin
         ack      = 1'b0;
         resp_err = 1'b0;
      end
   end

   assign m_axi_awaddr  = awaddr_r;
   assign m_axi_awvalid = awvalid_r;
   assign m_axi_wdata   = wdata_r;
   assign m_axi_wvalid  = wvalid_r;
   assign m_axi_bready  = bready_r;

endmodule

// File: rtl/nn_config_sequencer.sv
// nn_config_sequencer
// Replays the zyNet weight/bias loading register sequence as an AXI4-Lite
// write master: soft reset, then a weight pass and a bias pass over all
// layers, fetching each weight/bias word from a 1-cycle-latency ROM.
// Ports:
//   s_axi_aclk, s_axi_aresetn      : clock, async active-low reset
//   start / busy / done / error    : control and status
//   layer_idx, layer_neurons,
//   layer_weights                  : external per-layer descriptor lookup
//   rom_en, rom_addr, rom_data     : packed weight/bias ROM
//   m_axi_*                        : AXI4-Lite write master channels
module nn_config_sequencer
   import nn_cfg_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_LAYERS = 1,
   parameter int ROM_AW     = 16,
   parameter int CNT_W      = 16
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_aresetn,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [4:0]            layer_idx,
   input  logic [CNT_W-1:0]      layer_neurons,
   input  logic [CNT_W-1:0]      layer_weights,
   output logic                  rom_en,
   output logic [ROM_AW-1:0]     rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [31:0]           m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [31:0]           m_axi_wdata,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready
);

   localparam logic [4:0] LAST_LAYER = 5'(NUM_LAYERS);

   state_t              state_r, state_s;
   state_t              ret_r, ret_s;
   logic [4:0]          layer_r, layer_s;
   logic [CNT_W-1:0]    neuron_r, neuron_s;
   logic [CNT_W-1:0]    wcnt_r, wcnt_s;
   logic [ROM_AW-1:0]   rom_addr_r, rom_addr_s;
   logic                error_r, error_s;
   logic                busy_r, done_r, rom_en_r;

   logic                req_s;
   logic [31:0]         addr_s, data_s;
   logic                ack_s, resp_err_s;

   logic                last_neuron_s, last_wt_s, last_layer_s;
   logic [4:0]          layer_step_s;
   state_t              adv_w_s, adv_b_s;
   logic [4:0]          adv_layer_s;
   logic [CNT_W-1:0]    adv_neuron_s;

   // Last-element tests compare against count-1 so a counter never has to
   // reach (and wrap past) the CNT_W maximum. Callers guarantee count != 0.
   assign last_neuron_s = (neuron_r == (layer_neurons - CNT_W'(1)));
   assign last_wt_s     = (wcnt_r == (layer_weights - CNT_W'(1)));
   assign last_layer_s  = (layer_r == LAST_LAYER);
   assign layer_step_s  = last_layer_s ? 5'd1 : (layer_r + 5'd1);

   // Where to go after finishing a neuron: next neuron, next layer, or the
   // next pass (layer counter restarts at 1 for the bias pass).
   assign adv_w_s      = last_neuron_s ? (last_layer_s ? ST_LAYER_B : ST_LAYER_W) : ST_NEURON_W;
   assign adv_b_s      = last_neuron_s ? (last_layer_s ? ST_FINISH : ST_LAYER_B) : ST_NEURON_B;
   assign adv_layer_s  = last_neuron_s ? layer_step_s : layer_r;
   assign adv_neuron_s = last_neuron_s ? {CNT_W{1'b0}} : (neuron_r + CNT_W'(1));

   // Next-state, counter updates and write requests. Counters advance at
   // issue time; the write payload is already latched by the AXI engine.
   always_comb begin
      state_s    = state_r;
      ret_s      = ret_r;
      layer_s    = layer_r;
      neuron_s   = neuron_r;
      wcnt_s     = wcnt_r;
      rom_addr_s = rom_addr_r;
      error_s    = error_r;
      req_s      = 1'b0;
      addr_s     = 32'd0;
      data_s     = 32'd0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s    = ST_SRST;
               error_s    = 1'b0;
               rom_addr_s = {ROM_AW{1'b0}};
               layer_s    = 5'd0;
               neuron_s   = {CNT_W{1'b0}};
               wcnt_s     = {CNT_W{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SRST: begin
            req_s   = 1'b1;
            addr_s  = ADDR_SRST;
            data_s  = 32'd0;
            layer_s = 5'd1;
            ret_s   = ST_LAYER_W;
            state_s = ST_WAIT_B;
         end
         ST_LAYER_W: begin
            if (layer_neurons == {CNT_W{1'b0}}) begin
               // empty layer: skip silently, not even a layer-select write
               layer_s = layer_step_s;
               state_s = last_layer_s ? ST_LAYER_B : ST_LAYER_W;
            end else begin
               req_s    = 1'b1;
               addr_s   = ADDR_LAYER;
               data_s   = 32'(layer_r);
               neuron_s = {CNT_W{1'b0}};
               ret_s    = ST_NEURON_W;
               state_s  = ST_WAIT_B;
            end
         end
         ST_NEURON_W: begin
            req_s   = 1'b1;
            addr_s  = ADDR_NEURON;
            data_s  = 32'(neuron_r);
            wcnt_s  = {CNT_W{1'b0}};
            state_s = ST_WAIT_B;
            if (layer_weights == {CNT_W{1'b0}}) begin
               ret_s    = adv_w_s;
               layer_s  = adv_layer_s;
               neuron_s = adv_neuron_s;
            end else begin
               ret_s = ST_FETCH_W;
            end
         end
         ST_FETCH_W: begin
            rom_addr_s = rom_addr_r + ROM_AW'(1);
            state_s    = ST_WEIGHT;
         end
         ST_WEIGHT: begin
            req_s   = 1'b1;
            addr_s  = ADDR_WEIGHT;
            data_s  = 32'(rom_data);
            state_s = ST_WAIT_B;
            if (last_wt_s) begin
               ret_s    = adv_w_s;
               layer_s  = adv_layer_s;
               neuron_s = adv_neuron_s;
            end else begin
               wcnt_s = wcnt_r + CNT_W'(1);
               ret_s  = ST_FETCH_W;
            end
         end
         ST_LAYER_B: begin
            if (layer_neurons == {CNT_W{1'b0}}) begin
               layer_s = layer_step_s;
               state_s = last_layer_s ? ST_FINISH : ST_LAYER_B;
            end else begin
               req_s    = 1'b1;
               addr_s   = ADDR_LAYER;
               data_s   = 32'(layer_r);
               neuron_s = {CNT_W{1'b0}};
               ret_s    = ST_NEURON_B;
               state_s  = ST_WAIT_B;
            end
         end
         ST_NEURON_B: begin
            req_s   = 1'b1;
            addr_s  = ADDR_NEURON;
            data_s  = 32'(neuron_r);
            ret_s   = ST_FETCH_B;
            state_s = ST_WAIT_B;
         end
         ST_FETCH_B: begin
            rom_addr_s = rom_addr_r + ROM_AW'(1);
            state_s    = ST_BIAS;
         end
         ST_BIAS: begin
            req_s    = 1'b1;
            addr_s   = ADDR_BIAS;
            data_s   = 32'(rom_data);
            ret_s    = adv_b_s;
            layer_s  = adv_layer_s;
            neuron_s = adv_neuron_s;
            state_s  = ST_WAIT_B;
         end
         ST_WAIT_B: begin
            if (ack_s) begin
               if (resp_err_s) begin
                  error_s = 1'b1;
                  state_s = ST_FINISH;
               end else begin
                  state_s = ret_r;
               end
            end else begin
               state_s = ST_WAIT_B;
            end
         end
         ST_FINISH: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered status outputs (decoded from next state)
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_r    <= ST_IDLE;
         ret_r      <= ST_IDLE;
         layer_r    <= 5'd0;
         neuron_r   <= {CNT_W{1'b0}};
         wcnt_r     <= {CNT_W{1'b0}};
         rom_addr_r <= {ROM_AW{1'b0}};
         error_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         rom_en_r   <= 1'b0;
      end else begin
         state_r    <= state_s;
         ret_r      <= ret_s;
         layer_r    <= layer_s;
         neuron_r   <= neuron_s;
         wcnt_r     <= wcnt_s;
         rom_addr_r <= rom_addr_s;
         error_r    <= error_s;
         busy_r     <= (state_s != ST_IDLE) && (state_s != ST_FINISH);
         done_r     <= (state_s == ST_FINISH);
         rom_en_r   <= (state_s == ST_FETCH_W) || (state_s == ST_FETCH_B);
      end
   end

   axil_single_write u_wr (
      .s_axi_aclk    (s_axi_aclk),
      .s_axi_aresetn (s_axi_aresetn),
      .req           (req_s),
      .addr          (addr_s),
      .data          (data_s),
      .ack           (ack_s),
      .resp_err      (resp_err_s),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready)
   );

   assign busy      = busy_r;
   assign done      = done_r;
   assign error     = error_r;
   assign layer_idx = layer_r;
   assign rom_en    = rom_en_r;
   assign rom_addr  = rom_addr_r;

endmodule

// File: tb/tb_nn_config_sequencer.sv
// tb_nn_config_sequencer
// Directed bench: a one-layer network with a negedge-driven AXI4-Lite slave
// model (programmable AW/W ready delays and an injectable error response) and
// a ROM returning address+1. Writes are logged and compared with
// hand-computed register sequences.
module tb_nn_config_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, error;
   logic [4:0]  layer_idx;
   logic [15:0] layer_neurons = 16'd2;
   logic [15:0] layer_weights = 16'd3;
   logic        rom_en;
   logic [15:0] rom_addr;
   logic [15:0] rom_data;
   logic [31:0] awaddr, wdata;
   logic        awvalid, wvalid, bready;
   logic        awready, wready, bvalid;
   logic [1:0]  bresp;

   int n_tests = 0;
   int n_fail  = 0;

   // slave model configuration and state
   int aw_delay = 0, w_delay = 0, err_at = 0;
   int aw_wait = 0, w_wait = 0, aw_hi = 0, w_hi = 0, cur_awh = 0, cur_wh = 0;
   bit got_aw = 1'b0, got_w = 1'b0, b_fire = 1'b0;
   logic [31:0] cur_addr, cur_data;
   logic [31:0] log_addr [64];
   logic [31:0] log_data [64];
   int          log_awh  [64];
   int          log_wh   [64];
   int          n_wr = 0;
   int          done_cnt = 0;
   logic [31:0] exp_addr [16];
   logic [31:0] exp_data [16];

   nn_config_sequencer #(
      .DATA_WIDTH (16),
      .NUM_LAYERS (1),
      .ROM_AW     (16),
      .CNT_W      (16)
   ) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .layer_idx     (layer_idx),
      .layer_neurons (layer_neurons),
      .layer_weights (layer_weights),
      .rom_en        (rom_en),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .m_axi_awaddr  (awaddr),
      .m_axi_awvalid (awvalid),
      .m_axi_awready (awready),
      .m_axi_wdata   (wdata),
      .m_axi_wvalid  (wvalid),
      .m_axi_wready  (wready),
      .m_axi_bresp   (bresp),
      .m_axi_bvalid  (bvalid),
      .m_axi_bready  (bready)
   );

   always #5 clk = ~clk;

   // ROM model: data for the address seen with rom_en appears after the next edge
   initial begin
      logic [15:0] pend;
      rom_data = 16'd0;
      forever begin
         @(negedge clk);
         if (rom_en) begin
            pend = rom_addr + 16'd1;
            @(posedge clk);
            #1 rom_data = pend;
         end
      end
   end

   // Slave model: readies decided at negedge take effect at the next posedge
   initial begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            got_aw = 1'b0; got_w = 1'b0; b_fire = 1'b0;
            aw_wait = 0; w_wait = 0; aw_hi = 0; w_hi = 0;
         end else begin
            if (done) done_cnt++;
            if (b_fire) begin bvalid = 1'b0; b_fire = 1'b0; end
            if (got_aw && got_w && !bvalid) begin
               if (n_wr < 64) begin
                  log_addr[n_wr] = cur_addr; log_data[n_wr] = cur_data;
                  log_awh[n_wr] = cur_awh;   log_wh[n_wr] = cur_wh;
               end
               n_wr++;
               bresp  = (n_wr == err_at) ? 2'b10 : 2'b00;
               bvalid = 1'b1;
               got_aw = 1'b0; got_w = 1'b0;
            end
            awready = 1'b0;
            if (awvalid && !got_aw) begin
               aw_hi++;
               if (aw_wait >= aw_delay) begin
                  awready = 1'b1; cur_addr = awaddr; got_aw = 1'b1;
                  cur_awh = aw_hi; aw_hi = 0; aw_wait = 0;
               end else aw_wait++;
            end
            wready = 1'b0;
            if (wvalid && !got_w) begin
               w_hi++;
               if (w_wait >= w_delay) begin
                  wready = 1'b1; cur_data = wdata; got_w = 1'b1;
                  cur_wh = w_hi; w_hi = 0; w_wait = 0;
               end else w_wait++;
            end
            if (bvalid && bready) b_fire = 1'b1;
         end
      end
   end

   task automatic put_exp(input int i, input logic [31:0] a, input logic [31:0] d);
      exp_addr[i] = a;
      exp_data[i] = d;
   endtask

   // 1 layer, 2 neurons, 3 weights, ROM[i] = i+1
   task automatic load_exp_basic();
      put_exp(0, 32'd28, 32'd0);  put_exp(1, 32'd12, 32'd1);  put_exp(2, 32'd16, 32'd0);
      put_exp(3, 32'd0, 32'd1);   put_exp(4, 32'd0, 32'd2);   put_exp(5, 32'd0, 32'd3);
      put_exp(6, 32'd16, 32'd1);  put_exp(7, 32'd0, 32'd4);   put_exp(8, 32'd0, 32'd5);
      put_exp(9, 32'd0, 32'd6);   put_exp(10, 32'd12, 32'd1); put_exp(11, 32'd16, 32'd0);
      put_exp(12, 32'd4, 32'd7);  put_exp(13, 32'd16, 32'd1); put_exp(14, 32'd4, 32'd8);
   endtask

   // 1 layer, 2 neurons, 0 weights: biases sit at ROM addresses 0 and 1
   task automatic load_exp_zero_w();
      put_exp(0, 32'd28, 32'd0); put_exp(1, 32'd12, 32'd1); put_exp(2, 32'd16, 32'd0);
      put_exp(3, 32'd16, 32'd1); put_exp(4, 32'd12, 32'd1); put_exp(5, 32'd16, 32'd0);
      put_exp(6, 32'd4, 32'd1);  put_exp(7, 32'd16, 32'd1); put_exp(8, 32'd4, 32'd2);
   endtask

   // Pulse start, optionally pulse it again mid-run, wait (bounded) for done
   task automatic run_seq(input int mid_start, output logic busy_seen);
      int cyc;
      n_wr = 0;
      done_cnt = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      busy_seen = busy;
      cyc = 0;
      while (done_cnt == 0 && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == mid_start) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            cyc++;
         end
      end
      repeat (6) @(posedge clk);
      #1;
      n_tests++;
      if (done_cnt == 0) begin
         n_fail++;
         $display("FAIL run_timeout: done not seen after %0d cycles", cyc);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({busy, done, error, rom_en, awvalid, wvalid, bready} !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {busy, done, error, rom_en, awvalid, wvalid, bready});
      end
      n_tests++;
      if ({layer_idx, rom_addr} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_cnt: layer_idx=%0d rom_addr=%0d expected 0/0", layer_idx, rom_addr);
      end
      n_tests++;
      if ({awaddr, wdata} !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_bus: awaddr=%h wdata=%h expected 0/0", awaddr, wdata);
      end
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({busy, done, awvalid, rom_en} !== 4'd0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %b expected 0000", {busy, done, awvalid, rom_en});
      end
   endtask

   task automatic test_basic();
      logic bs;
      layer_neurons = 16'd2; layer_weights = 16'd3;
      aw_delay = 0; w_delay = 0; err_at = 0;
      load_exp_basic();
      run_seq(0, bs);
      n_tests++;
      if (bs !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bs); end
      n_tests++;
      if (n_wr != 15) begin n_fail++; $display("FAIL basic_count: got %0d expected 15", n_wr); end
      for (int i = 0; i < 15 && i < n_wr; i++) begin
         n_tests++;
         if ({log_addr[i], log_data[i]} !== {exp_addr[i], exp_data[i]}) begin
            n_fail++;
            $display("FAIL basic_wr%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                     log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
         end
      end
      n_tests++;
      if ({done_cnt == 1, error, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL basic_status: done_cnt=%0d error=%b busy=%b expected 1/0/0", done_cnt, error, busy);
      end
   endtask

   task automatic test_backpressure();
      logic bs;
      layer_neurons = 16'd2; layer_weights = 16'd3; err_at = 0;
      load_exp_basic();
      for (int pass = 0; pass < 2; pass++) begin
         aw_delay = (pass == 0) ? 3 : 0;
         w_delay  = (pass == 0) ? 0 : 3;
         run_seq(0, bs);
         n_tests++;
         if (n_wr != 15) begin n_fail++; $display("FAIL bp%0d_count: got %0d expected 15", pass, n_wr); end
         n_tests++;
         if (log_awh[0] != ((pass == 0) ? 4 : 1) || log_wh[0] != ((pass == 0) ? 1 : 4)) begin
            n_fail++;
            $display("FAIL bp%0d_hold: aw %0d w %0d cycles, expected %0d/%0d", pass,
                     log_awh[0], log_wh[0], (pass == 0) ? 4 : 1, (pass == 0) ? 1 : 4);
         end
         n_tests++;
         if ({log_addr[14], log_data[14]} !== {exp_addr[14], exp_data[14]} || done_cnt != 1) begin
            n_fail++;
            $display("FAIL bp%0d_last: got (%0d,%0d) done_cnt=%0d expected (4,8) 1", pass,
                     log_addr[14], log_data[14], done_cnt);
         end
      end
      aw_delay = 0; w_delay = 0;
   endtask

   task automatic test_error();
      logic bs;
      layer_neurons = 16'd2; layer_weights = 16'd3; err_at = 5;
      load_exp_basic();
      run_seq(0, bs);
      n_tests++;
      if (n_wr != 5) begin n_fail++; $display("FAIL err_count: got %0d expected 5", n_wr); end
      n_tests++;
      if ({log_addr[4], log_data[4]} !== {exp_addr[4], exp_data[4]}) begin
         n_fail++;
         $display("FAIL err_wr4: got (%0d,%0d) expected (0,2)", log_addr[4], log_data[4]);
      end
      n_tests++;
      if ({error, busy, done_cnt == 1} !== 3'b101) begin
         n_fail++;
         $display("FAIL err_status: error=%b busy=%b done_cnt=%0d expected 1/0/1", error, busy, done_cnt);
      end
      err_at = 0;
   endtask

   task automatic test_mid_reset();
      logic bs;
      int cyc;
      layer_neurons = 16'd2; layer_weights = 16'd3;
      load_exp_basic();
      n_wr = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc = 0;
      while (!(n_wr >= 4 && awvalid) && cyc < 500) begin
         @(posedge clk); #2;
         cyc++;
      end
      n_tests++;
      if (cyc >= 500) begin n_fail++; $display("FAIL midrst_wait: 5th write never issued"); end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({awvalid, wvalid, bready, busy, rom_en} !== 5'd0) begin
         n_fail++;
         $display("FAIL midrst_drop: got %b expected 00000", {awvalid, wvalid, bready, busy, rom_en});
      end
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      run_seq(0, bs);
      n_tests++;
      if (n_wr != 15) begin n_fail++; $display("FAIL midrst_count: got %0d expected 15", n_wr); end
      for (int i = 0; i < 15 && i < n_wr; i++) begin
         n_tests++;
         if ({log_addr[i], log_data[i]} !== {exp_addr[i], exp_data[i]}) begin
            n_fail++;
            $display("FAIL midrst_wr%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                     log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      logic bs;
      layer_neurons = 16'd2; layer_weights = 16'd3;
      load_exp_basic();
      run_seq(12, bs);
      n_tests++;
      if (n_wr != 15 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL busy_start: writes=%0d done_cnt=%0d expected 15/1", n_wr, done_cnt);
      end
      n_tests++;
      if ({log_addr[7], log_data[7]} !== {exp_addr[7], exp_data[7]}) begin
         n_fail++;
         $display("FAIL busy_start_wr7: got (%0d,%0d) expected (0,4)", log_addr[7], log_data[7]);
      end
   endtask

   task automatic test_zero_neurons();
      logic bs;
      layer_neurons = 16'd0; layer_weights = 16'd3;
      run_seq(0, bs);
      n_tests++;
      if (n_wr != 1) begin n_fail++; $display("FAIL zn_count: got %0d expected 1", n_wr); end
      n_tests++;
      if ({log_addr[0], log_data[0]} !== {32'd28, 32'd0}) begin
         n_fail++;
         $display("FAIL zn_wr0: got (%0d,%0d) expected (28,0)", log_addr[0], log_data[0]);
      end
      n_tests++;
      if ({done_cnt == 1, error, rom_addr} !== {1'b1, 1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL zn_status: done_cnt=%0d error=%b rom_addr=%0d expected 1/0/0",
                  done_cnt, error, rom_addr);
      end
   endtask

   task automatic test_zero_weights();
      logic bs;
      layer_neurons = 16'd2; layer_weights = 16'd0;
      load_exp_zero_w();
      run_seq(0, bs);
      n_tests++;
      if (n_wr != 9) begin n_fail++; $display("FAIL zw_count: got %0d expected 9", n_wr); end
      for (int i = 0; i < 9 && i < n_wr; i++) begin
         n_tests++;
         if ({log_addr[i], log_data[i]} !== {exp_addr[i], exp_data[i]}) begin
            n_fail++;
            $display("FAIL zw_wr%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                     log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_error();
      test_mid_reset();
      test_start_while_busy();
      test_zero_neurons();
      test_zero_weights();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nn_config_sequencer.md
Name: nn_config_sequencer

Overview:
- Hardware replacement for the software/testbench weight-and-bias loading loop of the zyNet accelerator.
- Acts as an AXI4-Lite write master into the zyNet slave register map:
  - 28 = soft reset
  - 12 = layer select
  - 16 = neuron select
  - 0 = weight
  - 4 = bias
- Reads packed weights, then biases, from a 1-cycle-latency ROM/BRAM and replays the exact register write sequence.
- Asserts done so the data-feed logic can start streaming inputs.

Parameters:
- DATA_WIDTH, 16, weight/bias word width; zero-extended to 32 bits on wdata.
- NUM_LAYERS, 1, number of layers configured (1..31).
- ROM_AW, 16, ROM word-address width.
- CNT_W, 16, width of neuron and weight counters.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins configuration when idle.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of sequence (success or error).
- error  out  1  sticky; set on non-OKAY bresp; cleared by next accepted start.
- layer_idx  out  5  current layer (1-based); addresses external layer descriptor table.
- layer_neurons  in  CNT_W  neuron count of layer_idx (combinational lookup).
- layer_weights  in  CNT_W  weights per neuron of layer_idx.
- rom_en  out  1  ROM read strobe.
- rom_addr  out  ROM_AW  ROM word address.
- rom_data  in  DATA_WIDTH  ROM data, valid the cycle after rom_en.
- m_axi_awaddr  out  32  write address.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.

Behaviour:
- Reset: all outputs 0; state IDLE; counters and rom_addr 0; error 0. Reset mid-operation aborts immediately: no further writes, valids drop asynchronously.
- Sequence, one write outstanding at a time:
  1. SRST: write 28←0.
  2. Weight pass, for k=1..NUM_LAYERS: write 12←k; for j=0..layer_neurons-1: write 16←j, then layer_weights writes 0←{zeros,rom_data}.
  3. Bias pass, same layer loop: write 12←k; for each j: write 16←j, then one write 4←{zeros,rom_data}.
- States: IDLE, SRST, LAYER_W, NEURON_W, FETCH_W, WEIGHT, LAYER_B, NEURON_B, FETCH_B, BIAS, WAIT_B, FINISH. WAIT_B returns to a recorded next-state.
- ROM layout: all weights in (layer, neuron, index) order starting at address 0, immediately followed by all biases in (layer, neuron) order. rom_addr increments by 1 per accepted fetch and never resets between passes.
- FETCH: rom_en high for 1 cycle; data is captured into the wdata register on the following cycle, then the write issues.
- AXI write rules:
  - awvalid and wvalid assert together in the same cycle.
  - Each deasserts independently on its own handshake; neither drops before its handshake.
  - bready=1 only in WAIT_B.
  - The next write issues no earlier than the cycle after the bvalid&bready handshake.
- Error: bresp≠2'b00 sets error and goes to FINISH. Remaining writes are skipped.
- FINISH: done=1 for one cycle, busy→0, then IDLE.
- Boundary conditions:
  - start while busy: ignored.
  - Layer with layer_neurons=0: no writes for that layer, including no layer-select write; rom_addr unchanged.
  - layer_weights=0: neuron-select write issued, no weight writes.
  - Counters compare with (count-1) and must not wrap at CNT_W max.
- Minimum writes per handshake: 3 cycles with zero-wait slave (issue, B, next).

Decomposition:
- Package nn_cfg_pkg holds:
  - Register offsets: ADDR_WEIGHT=0, ADDR_BIAS=4, ADDR_LAYER=12, ADDR_NEURON=16, ADDR_SRST=28.
  - State encoding constants.
  - BRESP_OKAY.
- Sub-module axil_single_write: handles one AW/W/B transaction with req/ack/resp_err. The sequencer FSM drives only address and data.

Test Plan:
- NUM_LAYERS=1, 2 neurons, 3 weights, zero-wait slave, ROM[i]=i+1:
  - Exactly 15 writes: (28,0),(12,1),(16,0),(0,1),(0,2),(0,3),(16,1),(0,4),(0,5),(0,6),(12,1),(16,0),(4,7),(16,1),(4,8).
  - done pulses once; error=0.
- Backpressure:
  - awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 4 cycles, one transaction counted.
  - Then wready delayed, awready immediate → symmetric result.
- bresp=2'b10 on 5th write → error=1, done pulse, no 6th write, busy=0.
- Reset low mid weight pass:
  - All valids 0 within the same cycle; state IDLE.
  - A restart replays the full sequence from (28,0) with rom_addr 0.
- start pulsed while busy → no effect on sequence or write count.
- layer_neurons=0 for layer 1 → only the (28,0) write occurs; done after it.
